// File: rtl/wdt_pkg.sv
// Purpose  : shared types for the watchdog supervisor (FSM states, fault codes, elapsed width).
// Latency  : n/a (types and a pure helper function only).
// Backpres.: n/a.
// Contents : state_t (IDLE/ARMED/WARN/BITE), fault_t (NONE/TIMEOUT/EARLY), EL_W, sat_inc().
package wdt_pkg;

    localparam int EL_W = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        WARN  = 3'd2,
        BITE  = 3'd3
    } state_t;

    typedef enum logic [1:0] {
        FAULT_NONE    = 2'b00,
        FAULT_TIMEOUT = 2'b01,
        FAULT_EARLY   = 2'b10
    } fault_t;

    // Increment that sticks at all-ones instead of wrapping back to zero.
    function automatic logic [EL_W-1:0] sat_inc(input logic [EL_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/wdt_pulse_stretch.sv
// Purpose  : turns a one-cycle start strobe into a bite level exactly BITE_CYCLES clocks long.
// Latency  : bite rises on the edge that samples start; done is high in the last bite cycle.
// Backpres.: none; a start while bite is already high is not expected and reloads the count.
// Ports    : clk, rst (async active-low), start (in), bite (registered out), done (out, last cycle).
module wdt_pulse_stretch #(
    parameter int BITE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic bite,
    output logic done
);

    localparam int CW = (BITE_CYCLES > 1) ? $clog2(BITE_CYCLES) : 1;

    // Counts the remaining bite cycles after the current one.
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bite <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            bite <= 1'b1;
            cnt  <= CW'(BITE_CYCLES - 1);
        end else if (bite) begin
            if (cnt == '0) begin
                bite <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign done = bite && (cnt == '0);

endmodule

// File: rtl/wdt_supervisor.sv
// Purpose  : enables the 1 ms timer, counts its ticks between kicks, raises bark then a stretched bite.
// Latency  : bark/bite/state/elapsed update on the edge that samples the causing tick, kick or arm.
// Backpres.: none; tick_1ms and kick are single-cycle strobes consumed every cycle, ignored in BITE.
// Ports    : clk, rst (async active-low), tick_1ms, kick, arm in; timer_en, elapsed[15:0],
//            bark, bite, fault_code[1:0], state[2:0] out (all registered).
// Option   : define WDT_WINDOW_EN to treat a kick in ARMED with elapsed < WINDOW_MS as a fault.
module wdt_supervisor
    import wdt_pkg::*;
#(
    parameter int TIMEOUT_MS  = 100,
    parameter int WARN_MS     = 80,
    parameter int BITE_CYCLES = 16,
    parameter int WINDOW_MS   = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick_1ms,
    input  logic            kick,
    input  logic            arm,
    output logic            timer_en,
    output logic [EL_W-1:0] elapsed,
    output logic            bark,
    output logic            bite,
    output logic [1:0]      fault_code,
    output logic [2:0]      state
);

    generate
        if (TIMEOUT_MS < 1 || TIMEOUT_MS > 65535 || WARN_MS < 1 || WARN_MS >= TIMEOUT_MS ||
            BITE_CYCLES < 1 || WINDOW_MS >= WARN_MS) begin : g_bad_params
            $error("wdt_supervisor: illegal parameter combination");
        end
    endgenerate

    localparam logic [EL_W-1:0] WARN_L = EL_W'(WARN_MS);
    localparam logic [EL_W-1:0] TO_L   = EL_W'(TIMEOUT_MS);
`ifdef WDT_WINDOW_EN
    localparam logic [EL_W-1:0] WIN_L  = EL_W'(WINDOW_MS);
`endif

    state_t          state_q, state_d;
    logic [EL_W-1:0] el_d;
    logic [EL_W-1:0] n;
    logic            bark_d;
    logic [1:0]      fault_d;
    logic            timer_en_d;
    logic            bite_start;
    logic            bite_done;

    wdt_pulse_stretch #(
        .BITE_CYCLES (BITE_CYCLES)
    ) u_stretch (
        .clk   (clk),
        .rst   (rst),
        .start (bite_start),
        .bite  (bite),
        .done  (bite_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            elapsed    <= '0;
            bark       <= 1'b0;
            fault_code <= FAULT_NONE;
            timer_en   <= 1'b0;
        end else begin
            state_q    <= state_d;
            elapsed    <= el_d;
            bark       <= bark_d;
            fault_code <= fault_d;
            timer_en   <= timer_en_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        el_d       = elapsed;
        bark_d     = bark;
        fault_d    = fault_code;
        bite_start = 1'b0;
        // Candidate elapsed value: a kick beats a coincident tick.
        n = kick ? '0 : (tick_1ms ? sat_inc(elapsed) : elapsed);

        case (state_q)
            IDLE: begin
                el_d   = '0;
                bark_d = 1'b0;
                if (arm) begin
                    state_d = ARMED;
                    fault_d = FAULT_NONE;
                end
            end

            ARMED: begin
                // Dropping arm outranks any threshold crossing in the same cycle.
                if (!arm) begin
                    state_d = IDLE;
                    el_d    = '0;
                    bark_d  = 1'b0;
                end
`ifdef WDT_WINDOW_EN
                else if (kick && (elapsed < WIN_L)) begin
                    // Kick arrived too soon after the last service: treated as a runaway controller.
                    state_d    = BITE;
                    fault_d    = FAULT_EARLY;
                    bark_d     = 1'b0;
                    bite_start = 1'b1;
                end
`endif
                else begin
                    el_d = n;
                    if (n == WARN_L) begin
                        state_d = WARN;
                        bark_d  = 1'b1;
                    end
                end
            end

            WARN: begin
                if (!arm) begin
                    state_d = IDLE;
                    el_d    = '0;
                    bark_d  = 1'b0;
                end else if (kick) begin
                    state_d = ARMED;
                    el_d    = '0;
                    bark_d  = 1'b0;
                end else begin
                    el_d = n;
                    if (n == TO_L) begin
                        state_d    = BITE;
                        fault_d    = FAULT_TIMEOUT;
                        bark_d     = 1'b0;
                        bite_start = 1'b1;
                    end
                end
            end

            BITE: begin
                // elapsed stays frozen as a record of how far the count got; kick/arm are ignored.
                bark_d = 1'b0;
                if (bite_done) begin
                    state_d = IDLE;
                    el_d    = '0;
                end
            end

            default: begin
                state_d = IDLE;
                el_d    = '0;
                bark_d  = 1'b0;
            end
        endcase

        timer_en_d = (state_d == ARMED) || (state_d == WARN);
    end

    assign state = state_q;

endmodule

// File: tb/tb_wdt_supervisor.sv
// Purpose  : self-checking bench for wdt_supervisor (TIMEOUT_MS=10, WARN_MS=8, BITE_CYCLES=4, WINDOW_MS=3).
// Latency  : outputs sampled 1 ns after each rising edge.
// Backpres.: n/a.
module tb_wdt_supervisor;

    logic        clk;
    logic        rst;
    logic        tick_1ms;
    logic        kick;
    logic        arm;
    logic        timer_en;
    logic [15:0] elapsed;
    logic        bark;
    logic        bite;
    logic [1:0]  fault_code;
    logic [2:0]  state;

    wdt_supervisor #(
        .TIMEOUT_MS  (10),
        .WARN_MS     (8),
        .BITE_CYCLES (4),
        .WINDOW_MS   (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1ms   (tick_1ms),
        .kick       (kick),
        .arm        (arm),
        .timer_en   (timer_en),
        .elapsed    (elapsed),
        .bark       (bark),
        .bite       (bite),
        .fault_code (fault_code),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output bundle: {state[2:0], elapsed[15:0], bark, bite, timer_en, fault_code[1:0]}.
    typedef struct {
        logic        arm;
        logic        kick;
        logic        tick;
        logic [23:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [23:0] sb_q[$];
    int          checks = 0;
    int          errors = 0;

    localparam int S_IDLE = 0, S_ARMED = 1, S_WARN = 2, S_BITE = 3;

    task automatic add(input logic a, input logic k, input logic t,
                       input int st, input int el, input int bk, input int bt,
                       input int ten, input int fc);
        vec_t v;
        v.arm  = a;
        v.kick = k;
        v.tick = t;
        v.exp  = {3'(st), 16'(el), 1'(bk), 1'(bt), 1'(ten), 2'(fc)};
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [23:0] exp);
        logic [23:0] act;
        act = {state, elapsed, bark, bite, timer_en, fault_code};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got st=%0d el=%0d bark=%b bite=%b ten=%b fault=%b, want st=%0d el=%0d bark=%b bite=%b ten=%b fault=%b",
                     nm, act[23:21], act[20:5], act[4], act[3], act[2], act[1:0],
                     exp[23:21], exp[20:5], exp[4], exp[3], exp[2], exp[1:0]);
        end
    endtask

    task automatic cyc(input logic a, input logic k, input logic t);
        arm      = a;
        kick     = k;
        tick_1ms = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1, "bench time limit expired");
    end

    initial begin
        rst      = 1'b0;
        arm      = 1'b0;
        kick     = 1'b0;
        tick_1ms = 1'b0;

        // ---- vector table ----
        // 1: arm, no kicks, run to timeout bite; kick/arm/tick ignored during bite.
        add(1, 0, 0, S_ARMED, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 7; i++) add(1, 0, 1, S_ARMED, i, 0, 0, 1, 0);
        add(1, 0, 1, S_WARN, 8, 1, 0, 1, 0);
        add(1, 0, 1, S_WARN, 9, 1, 0, 1, 0);
        add(1, 0, 1, S_BITE, 10, 0, 1, 0, 1);
        add(0, 1, 0, S_BITE, 10, 0, 1, 0, 1);
        add(0, 0, 1, S_BITE, 10, 0, 1, 0, 1);
        add(1, 1, 1, S_BITE, 10, 0, 1, 0, 1);
        add(0, 0, 0, S_IDLE, 0, 0, 0, 0, 1);
        add(0, 0, 1, S_IDLE, 0, 0, 0, 0, 1);
        add(1, 0, 0, S_ARMED, 0, 0, 0, 1, 0);
        // 2: kick every 5 ticks, 50 ticks total, elapsed peaks at 5.
        for (int k = 0; k < 10; k++) begin
            for (int j = 1; j <= 5; j++) add(1, 0, 1, S_ARMED, j, 0, 0, 1, 0);
            add(1, 1, 0, S_ARMED, 0, 0, 0, 1, 0);
        end
        // 3: reach bark, then kick clears it.
        for (int i = 1; i <= 7; i++) add(1, 0, 1, S_ARMED, i, 0, 0, 1, 0);
        add(1, 0, 1, S_WARN, 8, 1, 0, 1, 0);
        add(1, 1, 0, S_ARMED, 0, 0, 0, 1, 0);
        // 4: kick and tick together at elapsed=7.
        for (int i = 1; i <= 7; i++) add(1, 0, 1, S_ARMED, i, 0, 0, 1, 0);
        add(1, 1, 1, S_ARMED, 0, 0, 0, 1, 0);
        add(1, 0, 1, S_ARMED, 1, 0, 0, 1, 0);
        // arm drop coinciding with the warn crossing.
        for (int i = 2; i <= 7; i++) add(1, 0, 1, S_ARMED, i, 0, 0, 1, 0);
        add(0, 0, 1, S_IDLE, 0, 0, 0, 0, 0);
        // arm drop coinciding with the timeout crossing.
        add(1, 0, 0, S_ARMED, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 7; i++) add(1, 0, 1, S_ARMED, i, 0, 0, 1, 0);
        add(1, 0, 1, S_WARN, 8, 1, 0, 1, 0);
        add(1, 0, 1, S_WARN, 9, 1, 0, 1, 0);
        add(0, 0, 1, S_IDLE, 0, 0, 0, 0, 0);
        // 6: kick at elapsed=2 (inside the early window when the window check is built in).
        add(1, 0, 0, S_ARMED, 0, 0, 0, 1, 0);
        add(1, 0, 1, S_ARMED, 1, 0, 0, 1, 0);
        add(1, 0, 1, S_ARMED, 2, 0, 0, 1, 0);
`ifdef WDT_WINDOW_EN
        add(1, 1, 0, S_BITE, 2, 0, 1, 0, 2);
        for (int i = 0; i < 3; i++) add(1, 0, 0, S_BITE, 2, 0, 1, 0, 2);
        add(1, 0, 0, S_IDLE, 0, 0, 0, 0, 2);
        add(1, 0, 0, S_ARMED, 0, 0, 0, 1, 0);
`else
        add(1, 1, 0, S_ARMED, 0, 0, 0, 1, 0);
`endif
        // kick exactly at elapsed=3 is legal in both builds.
        for (int i = 1; i <= 3; i++) add(1, 0, 1, S_ARMED, i, 0, 0, 1, 0);
        add(1, 1, 0, S_ARMED, 0, 0, 0, 1, 0);
        add(0, 0, 0, S_IDLE, 0, 0, 0, 0, 0);

        // ---- reset state ----
        #12;
        chk("reset_state", 24'h0);
        @(negedge clk);
        rst = 1'b1;

        // ---- apply the table through the scoreboard ----
        for (int i = 0; i < vecs.size(); i++) begin
            logic [23:0] e;
            arm      = vecs[i].arm;
            kick     = vecs[i].kick;
            tick_1ms = vecs[i].tick;
            sb_q.push_back(vecs[i].exp);
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            chk($sformatf("vec%0d", i), e);
        end

        // ---- 5: asynchronous reset during the second bite cycle ----
        cyc(1, 0, 0);
        for (int i = 0; i < 10; i++) cyc(1, 0, 1);
        chk("bite_cycle1", {3'd3, 16'd10, 1'b0, 1'b1, 1'b0, 2'b01});
        cyc(1, 0, 0);
        chk("bite_cycle2", {3'd3, 16'd10, 1'b0, 1'b1, 1'b0, 2'b01});
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset_mid_bite", 24'h0);
        arm = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cyc(0, 0, 0);
        chk("idle_after_reset", 24'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wdt_supervisor.md
Name: wdt_supervisor

Overview:
Consumer side of the 1 ms watchdog timer. Enables the timer, counts its 1 ms timeout pulses, and requires periodic kicks from the controlling FSM. It raises an early warning (bark), then a stretched reset request (bite) with a latched fault code. It sits between the 1 ms timer and the system reset/controller logic.

Parameters:
TIMEOUT_MS, 100, ms without a kick before bite; 1..65535
WARN_MS, 80, ms without a kick before bark; 0 < WARN_MS < TIMEOUT_MS
BITE_CYCLES, 16, clk cycles that bite stays high; >= 1
WINDOW_MS, 10, earliest legal kick in ms; used only with the optional feature; < WARN_MS

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
tick_1ms  in  1  one-cycle pulse from the 1 ms timer's TimeOut output
kick  in  1  service strobe from the controller, one cycle
arm  in  1  level; 1 = supervision requested
timer_en  out  1  enable for the 1 ms timer
elapsed  out  16  ms since the last kick or arm
bark  out  1  warning level
bite  out  1  reset request pulse, BITE_CYCLES long
fault_code  out  2  00 none, 01 timeout, 10 early kick
state  out  3  current FSM state, for debug

Behaviour:
- Single clock. Reset is asynchronous, active-low on rst. All outputs are registered.
- Reset values: state=IDLE, timer_en=0, elapsed=0, bark=0, bite=0, fault_code=00, bite counter=0.
- States: IDLE=0, ARMED=1, WARN=2, BITE=3.
- IDLE:
  - timer_en=0, elapsed held at 0.
  - arm=1 -> ARMED on the next edge; elapsed=0; fault_code cleared to 00.
- ARMED:
  - timer_en=1.
  - Per edge: n = kick ? 0 : (tick_1ms ? elapsed+1 : elapsed). elapsed <= n.
  - n == WARN_MS -> WARN, bark <= 1.
- WARN:
  - timer_en=1, bark=1, elapsed updates by the same rule.
  - kick -> ARMED, elapsed=0, bark=0.
  - n == TIMEOUT_MS -> BITE, fault_code <= 01.
- BITE:
  - bite=1, bark=0, timer_en=0, elapsed frozen.
  - kick and arm are ignored.
  - After exactly BITE_CYCLES cycles in BITE -> IDLE, bite=0.
  - fault_code stays latched until the next IDLE->ARMED transition.
- arm=0 in ARMED or WARN -> IDLE next edge; elapsed=0, bark=0, no fault.
- Simultaneous events:
  - kick and tick_1ms in the same cycle: kick wins, elapsed=0.
  - arm=0 together with a threshold crossing: arm=0 wins.
- Latency:
  - bark rises 1 clk after the tick edge that makes elapsed == WARN_MS.
  - bite rises 1 clk after the tick edge that makes elapsed == TIMEOUT_MS.
- elapsed saturates at 16'hFFFF and never wraps. Unreachable with legal parameters; the saturation logic is still required.
- Reset asserted mid-operation clears everything immediately, including a bite in progress.

Optional Feature:
Macro WDT_WINDOW_EN.
- Defined: a kick in ARMED while elapsed < WINDOW_MS is a fault. Next state is BITE, fault_code=10, same bite length as a timeout.
- Undefined: kicks are legal at any elapsed value, WINDOW_MS is unused, and fault_code 10 is never produced.

Decomposition:
- Package wdt_pkg holds:
  - state encodings IDLE/ARMED/WARN/BITE (3-bit)
  - fault codes FAULT_NONE/FAULT_TIMEOUT/FAULT_EARLY (2-bit)
  - elapsed width constant 16
- One sub-module is natural: wdt_pulse_stretch, a BITE_CYCLES down-counter that produces bite and a done strobe.

Test Plan:
Parameters for all tests: TIMEOUT_MS=10, WARN_MS=8, BITE_CYCLES=4, WINDOW_MS=3.
1. Reset, arm=1, no kicks, 10 ticks -> bark rises after tick 8; after tick 10 bite=1 for exactly 4 clk; fault_code=01; state returns to IDLE; timer_en=0 during bite.
2. Arm, kick every 5 ticks for 50 ticks -> bark and bite never assert; elapsed peaks at 5.
3. Arm, 8 ticks (bark=1), then kick -> bark=0 next clk, state=ARMED, elapsed=0; fault_code stays 00.
4. kick and tick_1ms in the same cycle at elapsed=7 -> elapsed=0, no bark.
5. Assert rst low during cycle 2 of bite -> bite=0, state=IDLE, fault_code=00 immediately, without waiting for a clock edge.
6. With WDT_WINDOW_EN defined: kick at elapsed=2 -> bite for 4 clk, fault_code=10. Without the macro: same stimulus -> elapsed=0, no bite.
